// File: rtl/vedic_mult_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// vedic_mult_scheduler_pkg
// Shared definitions for the multiplier scheduler slice:
//   state_t        - 2-bit FSM encoding (IDLE, MUL, RSP)
//   DEF_NUM_REQ    - default number of requesters sharing the multiplier
//   DEF_ID_W       - default requester-ID width (clog2 of DEF_NUM_REQ)
//   OPND_W         - operand width of the shared multiplier
//   PROD_W         - full unsigned product width
// ---------------------------------------------------------------------------
package vedic_mult_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ID_W    = 2;
    localparam int OPND_W      = 8;
    localparam int PROD_W      = 16;

endpackage

// File: rtl/vedic_8X8.sv
// ---------------------------------------------------------------------------
// vedic_8X8
// Purely combinational 8x8 unsigned multiplier built with the Urdhva
// Tiryagbhyam (vertical and crosswise) decomposition: 2x2 cells combine
// into 4x4 blocks, four 4x4 blocks combine into the 8x8 result.
// Ports:
//   a [7:0]  - multiplicand
//   b [7:0]  - multiplier
//   p [15:0] - unsigned product a*b
// ---------------------------------------------------------------------------
module vedic_8X8
    import vedic_mult_scheduler_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [PROD_W-1:0] p
);

    // 2x2 cell: vertical/crosswise partial products with half-adder carries.
    function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
        logic cross_a;
        logic cross_b;
        logic c1;
        logic [3:0] r;
        cross_a = x[1] & y[0];
        cross_b = x[0] & y[1];
        c1      = cross_a & cross_b;
        r[0]    = x[0] & y[0];
        r[1]    = cross_a ^ cross_b;
        r[2]    = (x[1] & y[1]) ^ c1;
        r[3]    = (x[1] & y[1]) & c1;
        return r;
    endfunction

    // 4x4 block: low*low, the two crosswise terms shifted by 2, high*high by 4.
    function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        q0 = mul2(x[1:0], y[1:0]);
        q1 = mul2(x[3:2], y[1:0]);
        q2 = mul2(x[1:0], y[3:2]);
        q3 = mul2(x[3:2], y[3:2]);
        return {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
    endfunction

    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] r3;

    assign r0 = mul4(a[3:0], b[3:0]);
    assign r1 = mul4(a[7:4], b[3:0]);
    assign r2 = mul4(a[3:0], b[7:4]);
    assign r3 = mul4(a[7:4], b[7:4]);

    assign p = {8'b0, r0} + {4'b0, r1, 4'b0} + {4'b0, r2, 4'b0} + {r3, 8'b0};

endmodule

// File: rtl/vedic_mult_scheduler.sv
// ---------------------------------------------------------------------------
// vedic_mult_scheduler
// Shares a single vedic_8X8 multiplier between NUM_REQ requesters using a
// round-robin arbiter and a three-state FSM (IDLE -> MUL -> RSP -> IDLE).
// Ports:
//   clk          - sole clock, rising edge
//   rst_n        - synchronous active-low reset
//   req_valid    - per-requester request
//   req_a/req_b  - packed 8-bit operands, requester i at [8i+7:8i]
//   req_ready    - one-hot grant (only in IDLE)
//   rsp_valid    - product available (RSP state)
//   rsp_ready    - consumer accepts product
//   rsp_id       - requester owning rsp_product
//   rsp_product  - 16-bit unsigned product
//   busy         - high whenever the FSM is not in IDLE
//   op_count     - saturating count of completed response handshakes
// ---------------------------------------------------------------------------
module vedic_mult_scheduler
    import vedic_mult_scheduler_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [PROD_W-1:0]        rsp_product,
    output logic                     busy,
    output logic [15:0]              op_count
);

    state_t              state_reg,    state_next;
    logic [ID_W-1:0]     rr_ptr_reg,   rr_ptr_next;
    logic [ID_W-1:0]     id_reg,       id_next;
    logic [OPND_W-1:0]   op_a_reg,     op_a_next;
    logic [OPND_W-1:0]   op_b_reg,     op_b_next;
    logic [PROD_W-1:0]   product_reg,  product_next;
    logic [15:0]         op_count_reg, op_count_next;

    logic [PROD_W-1:0]   mul_out;
    logic [OPND_W-1:0]   a_arr [NUM_REQ];
    logic [OPND_W-1:0]   b_arr [NUM_REQ];

    logic                grant_found;
    logic [ID_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]  grant_vec;
    logic                req_hs;
    logic                rsp_hs;
    int                  scan_idx;

    // Unpack the flat operand buses into per-requester lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign a_arr[gi] = req_a[OPND_W*gi +: OPND_W];
            assign b_arr[gi] = req_b[OPND_W*gi +: OPND_W];
        end
    endgenerate

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    assign grant_vec = grant_found ? (NUM_REQ'(1) << grant_idx) : '0;
    assign req_ready = (state_reg == ST_IDLE) ? grant_vec : '0;
    assign req_hs    = |(req_valid & req_ready);
    assign rsp_hs    = rsp_valid & rsp_ready;

    // The only unregistered path: operand registers -> multiplier -> product reg.
    vedic_8X8 u_mult (
        .a (op_a_reg),
        .b (op_b_reg),
        .p (mul_out)
    );

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        id_next       = id_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        product_next  = product_reg;
        op_count_next = op_count_reg;

        case (state_reg)
            ST_IDLE: begin
                if (req_hs) begin
                    op_a_next   = a_arr[grant_idx];
                    op_b_next   = b_arr[grant_idx];
                    id_next     = grant_idx;
                    rr_ptr_next = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
                    state_next  = ST_MUL;
                end
            end
            ST_MUL: begin
                product_next = mul_out;
                state_next   = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_hs) begin
                    state_next = ST_IDLE;
                    if (op_count_reg != 16'hFFFF) begin
                        op_count_next = op_count_reg + 16'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            id_reg       <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            product_reg  <= '0;
            op_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            id_reg       <= id_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            product_reg  <= product_next;
            op_count_reg <= op_count_next;
        end
    end

    assign rsp_valid   = (state_reg == ST_RSP);
    assign busy        = (state_reg != ST_IDLE);
    assign rsp_id      = id_reg;
    assign rsp_product = product_reg;
    assign op_count    = op_count_reg;

endmodule

// File: tb/tb_vedic_mult_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vedic_mult_scheduler
// Self-checking bench: a cycle-level reference model of the arbiter/FSM
// predicts grants and state; expected products are queued at each request
// handshake and compared while the response is presented.
// ---------------------------------------------------------------------------
module tb_vedic_mult_scheduler;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_product;
    logic        busy;
    logic [15:0] op_count;

    vedic_mult_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .busy        (busy),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   m_state = 0;     // 0 idle, 1 mul, 2 rsp
    int   m_rr = 0;
    int   m_count = 0;
    exp_t sb[$];
    int   grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [3:0] pick(input logic [3:0] v, input int ptr, output int idx);
        int j;
        idx = 0;
        for (int k = 0; k < 4; k++) begin
            j = (ptr + k) % 4;
            if (v[j]) begin
                idx = j;
                return 4'b0001 << j;
            end
        end
        return 4'b0000;
    endfunction

    // Called just after a falling edge with inputs set; advances one cycle.
    task automatic step();
        logic [3:0]  exp_g;
        int          g;
        logic [7:0]  a8;
        logic [7:0]  b8;
        exp_t        e;
        #1;
        if (!rst_n) begin
            m_state = 0;
            m_rr    = 0;
            m_count = 0;
            sb.delete();
        end else begin
            check("busy", busy, (m_state != 0));
            check("op_count", op_count, m_count);
            case (m_state)
                0: begin
                    exp_g = pick(req_valid, m_rr, g);
                    check("req_ready_idle", req_ready, exp_g);
                    check("rsp_valid_idle", rsp_valid, 0);
                    if (exp_g != 4'b0) begin
                        a8 = req_a[8*g +: 8];
                        b8 = req_b[8*g +: 8];
                        e.id   = 2'(g);
                        e.prod = 16'(a8) * 16'(b8);
                        sb.push_back(e);
                        grants.push_back(g);
                        m_rr    = (g + 1) % 4;
                        m_state = 1;
                    end
                end
                1: begin
                    check("req_ready_mul", req_ready, 0);
                    check("rsp_valid_mul", rsp_valid, 0);
                    m_state = 2;
                end
                default: begin
                    check("req_ready_rsp", req_ready, 0);
                    check("rsp_valid_rsp", rsp_valid, 1);
                    if (sb.size() == 0) begin
                        check("sb_size", sb.size(), 1);
                    end else begin
                        e = sb[0];
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_product", rsp_product, e.prod);
                        if (rsp_ready) begin
                            void'(sb.pop_front());
                            $display("rsp id=%0d product=%0d count=%0d", rsp_id, rsp_product, m_count + 1);
                            if (m_count != 65535) m_count++;
                            n_done++;
                            m_state = 0;
                        end
                    end
                end
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_op(input int r, input logic [7:0] a, input logic [7:0] b);
        int g0;
        int d0;
        g0 = grants.size();
        d0 = n_done;
        req_a[8*r +: 8] = a;
        req_b[8*r +: 8] = b;
        req_valid = 4'b0001 << r;
        for (int i = 0; i < 10 && grants.size() == g0; i++) step();
        req_valid = 4'b0;
        for (int i = 0; i < 30 && n_done == d0; i++) step();
        check("do_op_done", n_done - d0, 1);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        int d0;
        int c0;
        rst_n = 1'b0;
        req_valid = 4'b0;
        req_a = 32'b0;
        req_b = 32'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_product", rsp_product, 0);
        check("rst_busy", busy, 0);
        check("rst_op_count", op_count, 0);
        @(negedge clk);

        // Single request and corner operands.
        do_op(0, 8'd9, 8'd27);
        check("single_count", op_count, 1);
        do_op(1, 8'd255, 8'd255);
        do_op(2, 8'd0, 8'd200);
        do_op(3, 8'd2, 8'd41);

        // Fairness from reset: all four valid continuously.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req_a = {8'd5, 8'd3, 8'd6, 8'd27};
        req_b = {8'd5, 8'd23, 8'd7, 8'd21};
        req_valid = 4'hF;
        g0 = grants.size();
        for (int i = 0; i < 40 && grants.size() < g0 + 5; i++) step();
        check("rr_grants", grants.size() - g0, 5);
        for (int k = 0; k < 5 && g0 + k < grants.size(); k++) begin
            check("rr_order", grants[g0+k], k % 4);
        end
        req_valid = 4'b0;
        for (int i = 0; i < 10 && m_state != 0; i++) step();

        // Backpressure: hold response 10 cycles while others request.
        rsp_ready = 1'b0;
        req_a[15:8] = 8'd17;
        req_b[15:8] = 8'd13;
        req_valid = 4'b0010;
        for (int i = 0; i < 10 && m_state != 2; i++) step();
        check("bp_in_rsp", m_state, 2);
        req_valid = 4'hF;
        repeat (10) step();
        c0 = m_count;
        rsp_ready = 1'b1;
        req_valid = 4'b0;
        step();
        #1;
        check("bp_count", op_count, c0 + 1);
        @(negedge clk);

        // Reset while in MUL aborts the operation.
        req_a[23:16] = 8'd100;
        req_b[23:16] = 8'd100;
        req_valid = 4'b0100;
        for (int i = 0; i < 10 && m_state != 1; i++) step();
        check("mid_in_mul", busy, 1);
        rst_n = 1'b0;
        req_valid = 4'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("mid_busy", busy, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_op_count", op_count, 0);
        @(negedge clk);
        do_op(2, 8'd6, 8'd7);

        // Random traffic across all requesters.
        d0 = n_done;
        for (int i = 0; i < 60000 && n_done - d0 < 10000; i++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_a = $urandom;
            req_b = $urandom;
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        check("rand_ops", n_done - d0, 10000);
        req_valid = 4'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && m_state != 0; i++) step();
        #1;
        check("final_op_count", op_count, m_count);
        check("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vedic_mult_scheduler.md
VEDIC_MULT_SCHEDULER -- requirements
Module: vedic_mult_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one 8x8 multiplier.
REQ-002 SHALL have parameter ID_W, default 2, requester-ID width (clog2 of NUM_REQ).
REQ-003 SHALL have ports clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have ports rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have ports req_a  input  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i].
REQ-007 SHALL have ports req_b  input  8*NUM_REQ  multiplier; same packing as req_a.
REQ-008 SHALL have ports req_ready  output  NUM_REQ  one-hot grant; operands accepted when req_valid[i] and req_ready[i] are both 1.
REQ-009 SHALL have ports rsp_valid  output  1  product available.
REQ-010 SHALL have ports rsp_ready  input  1  consumer accepts product.
REQ-011 SHALL have ports rsp_id  output  ID_W  index of the requester that owns rsp_product.
REQ-012 SHALL have ports rsp_product  output  16  unsigned product a*b.
REQ-013 SHALL have ports busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have ports op_count  output  16  number of completed response handshakes.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, RSP; no other reachable states.
REQ-016 In IDLE, req_ready SHALL be the round-robin grant: the first i with req_valid[i]=1, searching upward from rr_ptr with modulo-NUM_REQ wrap; all zeros if no request.
REQ-017 Outside IDLE, req_ready SHALL be all zeros; requests are held off, never dropped.
REQ-018 On a handshake at edge T: capture req_a/req_b of the granted requester into operand registers, capture its ID, set rr_ptr to (granted+1) mod NUM_REQ, go to MUL.
REQ-019 In MUL (edge T+1): register the multiplier output into the product register, go to RSP.
REQ-020 In RSP, rsp_valid SHALL be 1; rsp_product and rsp_id SHALL stay stable until handshake.
REQ-021 Latency SHALL be exactly 2 cycles from request handshake to rsp_valid=1; peak throughput is one operation per 3 cycles.
REQ-022 While rsp_ready=0 in RSP, SHALL stay in RSP indefinitely (backpressure); on rsp_valid&rsp_ready, go to IDLE and increment op_count.
REQ-023 op_count SHALL saturate at 16'hFFFF, with no wrap.
REQ-024 rsp_product SHALL be full 16-bit unsigned; 255*255 = 16'hFE01, and 0*x = 0.
REQ-025 rr_ptr SHALL update only on a request handshake; idle cycles SHALL not move it.
REQ-026 A requester deasserting req_valid before grant SHALL lose no state; no grant is issued to it.
REQ-027 rsp_valid SHALL be 0 in IDLE and MUL; only the multiplier's combinational path is unregistered.

Reset
REQ-028 When rst_n=0 at a rising edge: state=IDLE, rr_ptr=0, op_count=0, operand/product/ID registers=0.
REQ-029 After reset, outputs SHALL be req_ready=0 (if no req_valid), rsp_valid=0, rsp_id=0, rsp_product=0, busy=0.
REQ-030 Reset mid-operation (MUL or RSP) SHALL abort the in-flight product without emitting a response.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (2-bit), default NUM_REQ/ID_W, and the product width constant 16.
REQ-032 SHALL instantiate exactly one existing vedic_8X8 as the sole sub-module, fed from the operand registers.
REQ-033 Round-robin selection and FSM SHALL be local logic; no additional sub-modules.

Verification
REQ-034 Single request: req 0 sends a=9, b=27 -> rsp_valid 2 cycles after handshake, rsp_product=243, rsp_id=0, op_count=1.
REQ-035 Corner values: a=255, b=255 -> 16'hFE01; a=0, b=200 -> 0; a=2, b=41 -> 82.
REQ-036 Fairness: all 4 requesters valid continuously from reset -> grant order 0,1,2,3,0; each product is correct for its own operands (e.g. 27*21=567, 6*7=42, 3*23=69).
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RSP -> rsp_valid, product and ID held; req_ready=0 throughout; one count added on release.
REQ-038 Reset mid-op: rst_n=0 during MUL -> next cycle busy=0, rsp_valid=0, op_count=0; a fresh request then completes normally.
REQ-039 Scoreboard: random operands across all requesters for 10k ops -> every product equals a*b, every ID matches, no request lost, and op_count matches handshakes.
